// File: rtl/md_ctrl_if.sv
// -----------------------------------------------------------------------------
// md_ctrl_if -- execute-stage request / HI-LO control bundle for md_ctrl.
//
// Signals:
//   req_valid  execute-stage instruction valid
//   req_op     HI/LO op code (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//              5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 NONE)
//   int_req    interrupt/exception flush of the execute-stage instruction
//   md_start   one-cycle launch pulse to the multiply/divide unit
//   md_signed  launched op is signed (valid with md_start)
//   md_div     launched op is a divide (valid with md_start)
//   hi_we      write HI from rs (MTHI)
//   lo_we      write LO from rs (MTLO)
//   busy       unit occupied
//   stall      hold the execute stage and everything upstream
//   busy_cnt   remaining busy cycles
//
// Modports: master = pipeline side (drives requests), slave = md_ctrl.
// -----------------------------------------------------------------------------
interface md_ctrl_if;
    logic       req_valid;
    logic [3:0] req_op;
    logic       int_req;
    logic       md_start;
    logic       md_signed;
    logic       md_div;
    logic       hi_we;
    logic       lo_we;
    logic       busy;
    logic       stall;
    logic [3:0] busy_cnt;

    modport master (
        output req_valid, req_op, int_req,
        input  md_start, md_signed, md_div, hi_we, lo_we, busy, stall, busy_cnt
    );

    modport slave (
        input  req_valid, req_op, int_req,
        output md_start, md_signed, md_div, hi_we, lo_we, busy, stall, busy_cnt
    );
endinterface

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl -- HI/LO multiply/divide issue controller.
//
// Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the execute stage,
// launches the multiply/divide unit, tracks its fixed latency with a 4-bit
// down-counter and stalls the pipeline while a HI/LO op waits for the unit.
//
// Parameters:
//   MUL_LAT  busy cycles after a MULT/MULTU accept (2..15)
//   DIV_LAT  busy cycles after a DIV/DIVU accept (2..15)
//
// Ports:
//   clk             clock, all state on posedge
//   reset           synchronous, active-high reset
//   bus             md_ctrl_if.slave request/strobe bundle
//   perf_stall_cnt  32-bit saturating count of stall cycles
//                   (only when MD_CTRL_PERF_CNT_EN is defined)
//
// Optional feature macro: MD_CTRL_PERF_CNT_EN
// -----------------------------------------------------------------------------
module md_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MD_CTRL_PERF_CNT_EN
    output logic [31:0] perf_stall_cnt,
`endif
    md_ctrl_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic op_valid;   // op 1..8
    logic op_md;      // op 1..4, launches the unit
    logic op_mul;     // op 1..2
    logic accept;

    always_comb begin
        op_valid = (bus.req_op >= 4'd1) && (bus.req_op <= 4'd8);
        op_md    = (bus.req_op >= OP_MULT) && (bus.req_op <= OP_DIVU);
        op_mul   = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU);
        // Reset and a flush both veto acceptance so no strobe escapes.
        accept   = (state_q == IDLE) && bus.req_valid && !bus.int_req
                   && op_valid && !reset;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && op_md) begin
                    state_d = BUSY;
                    cnt_d   = op_mul ? MUL_LAT_C : DIV_LAT_C;
                end
            end
            BUSY: begin
                // int_req never aborts a running op; the count just runs out.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus.busy      = (state_q == BUSY);
        bus.busy_cnt  = cnt_q;
        // A flushed instruction is discarded, so it must not hold the pipe.
        bus.stall     = (state_q == BUSY) && bus.req_valid && !bus.int_req
                        && op_valid;
        bus.md_start  = accept && op_md;
        bus.md_signed = accept && ((bus.req_op == OP_MULT) || (bus.req_op == OP_DIV));
        bus.md_div    = accept && ((bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU));
        bus.hi_we     = accept && (bus.req_op == OP_MTHI);
        bus.lo_we     = accept && (bus.req_op == OP_MTLO);
    end

`ifdef MD_CTRL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (bus.stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_ctrl -- scoreboard bench for md_ctrl.
// Each driven cycle pushes the reference model's expected outputs into a
// queue; a monitor on the falling edge pops and compares. Directed scenarios
// are followed by randomized traffic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_md_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_ctrl_if bus ();

`ifdef MD_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .perf_stall_cnt(perf_stall_cnt), .bus(bus)
    );
`else
    md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    typedef struct {
        logic        start;
        logic        sgn;
        logic        div;
        logic        hwe;
        logic        lwe;
        logic        busy;
        logic        stall;
        logic [3:0]  cnt;
        logic [31:0] perf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state: cycles of occupancy left, cumulative stall count.
    int     rem      = 0;
    longint perf_tot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the expected outputs for it.
    task automatic drive(input logic v, input logic [3:0] op, input logic ir, input logic rst);
        exp_t e;
        bit is_rw, is_md, acc;
        @(posedge clk);
        #1;
        cycle++;
        reset         = rst;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.int_req   = ir;

        is_rw   = (op >= 1) && (op <= 8);
        is_md   = (op >= 1) && (op <= 4);
        e.busy  = (rem > 0);
        e.cnt   = 4'(rem);
        e.stall = (rem > 0) && v && is_rw && !ir;
        acc     = (rem == 0) && v && is_rw && !ir && !rst;
        e.start = acc && is_md;
        e.sgn   = (op == 1) || (op == 3);
        e.div   = (op == 3) || (op == 4);
        e.hwe   = acc && (op == 7);
        e.lwe   = acc && (op == 8);
        e.perf  = (perf_tot > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(perf_tot);
        e.cyc   = cycle;
        exp_q.push_back(e);

        if (rst) begin
            rem      = 0;
            perf_tot = 0;
        end else begin
            if (e.stall) perf_tot++;
            if (rem > 0)           rem--;
            else if (e.start)      rem = (op <= 2) ? MUL_LAT : DIV_LAT;
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("md_start", 32'(bus.md_start), 32'(e.start));
            if (e.start) begin
                chk("md_signed", 32'(bus.md_signed), 32'(e.sgn));
                chk("md_div", 32'(bus.md_div), 32'(e.div));
            end
            chk("hi_we", 32'(bus.hi_we), 32'(e.hwe));
            chk("lo_we", 32'(bus.lo_we), 32'(e.lwe));
            chk("busy", 32'(bus.busy), 32'(e.busy));
            chk("stall", 32'(bus.stall), 32'(e.stall));
            chk("busy_cnt", 32'(bus.busy_cnt), 32'(e.cnt));
`ifdef MD_CTRL_PERF_CNT_EN
            chk("perf_stall_cnt", perf_stall_cnt, e.perf);
`endif
        end
    end

    initial begin
        int wait_cyc;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.int_req   = 1'b0;

        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_cnt", 32'(bus.busy_cnt), 32'd0);

        // DIVU then MFLO held: stall cycles 1..10, released in cycle 11.
        drive(1, 4, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(1, 6, 0, 0);
            #1;
            chk("divu_mflo_stall", 32'(bus.stall), 32'd1);
        end
        drive(1, 6, 0, 0);
        #1;
        chk("divu_mflo_release", 32'(bus.stall), 32'd0);
`ifdef MD_CTRL_PERF_CNT_EN
        chk("perf_after_divu", perf_stall_cnt, 32'd10);
`endif

        // MULT accepted: start pulse then busy_cnt 5,4,3,2,1 then idle.
        drive(1, 1, 0, 0);
        #1;
        chk("mult_start", 32'(bus.md_start), 32'd1);
        chk("mult_signed", 32'(bus.md_signed), 32'd1);
        chk("mult_div", 32'(bus.md_div), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 0);
            #1;
            chk("mult_busy_cnt", 32'(bus.busy_cnt), 32'(6 - k));
        end
        drive(0, 0, 0, 0);
        #1;
        chk("mult_done", 32'(bus.busy), 32'd0);

        // MTHI, then MTHI under flush.
        drive(1, 7, 0, 0);
        #1;
        chk("mthi_we", 32'(bus.hi_we), 32'd1);
        drive(1, 7, 1, 0);
        #1;
        chk("mthi_flush_we", 32'(bus.hi_we), 32'd0);
        chk("mthi_busy", 32'(bus.busy), 32'd0);

        // DIV, flush in cycle 3 does not abort.
        drive(1, 3, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            if (k == 3) begin
                drive(1, 5, 1, 0);
                #1;
                chk("div_flush_stall", 32'(bus.stall), 32'd0);
            end else begin
                drive(0, 0, 0, 0);
                #1;
            end
            chk("div_busy", 32'(bus.busy), (k <= 10) ? 32'd1 : 32'd0);
        end

        // Reset in cycle 4 of a MULT, new MULT in cycle 5.
        drive(1, 2, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(1, 1, 0, 0);
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_cnt", 32'(bus.busy_cnt), 32'd0);
        chk("rst_mid_restart", 32'(bus.md_start), 32'd1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic       v, ir, rs;
            logic [3:0] op;
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 8));
            ir = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 63) == 0);
            drive(v, op, ir, rs);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
